// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default bit timing and the
// Hamming(7,4) codeword bit positions used by transmitter and receiver.
package uart_pkg;

  // State encoding shared with the receiver; state_out exposes it directly.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_e;

  // Default bit time, matching the receiver's 8x oversampling.
  localparam int CLKS_PER_BIT_DEF = 8;

  // Codeword width and the position of every parity/data bit inside it.
  localparam int HAM_CW_W   = 7;
  localparam int HAM_P1_POS = 0;
  localparam int HAM_P2_POS = 1;
  localparam int HAM_D0_POS = 2;
  localparam int HAM_P4_POS = 3;
  localparam int HAM_D1_POS = 4;
  localparam int HAM_D2_POS = 5;
  localparam int HAM_D3_POS = 6;

endpackage

// File: rtl/hamming74_encoder.sv
// Pure combinational Hamming(7,4) encoder: nibble d3..d0 in, codeword out.
module hamming74_encoder
  import uart_pkg::*;
(
  input  logic [3:0]          data_in,
  output logic [HAM_CW_W-1:0] cw
);

  // Place data bits and compute the three even-parity bits.
  always_comb begin
    cw             = 7'b000_0000;
    cw[HAM_P1_POS] = data_in[0] ^ data_in[1] ^ data_in[3];
    cw[HAM_P2_POS] = data_in[0] ^ data_in[2] ^ data_in[3];
    cw[HAM_D0_POS] = data_in[0];
    cw[HAM_P4_POS] = data_in[1] ^ data_in[2] ^ data_in[3];
    cw[HAM_D1_POS] = data_in[1];
    cw[HAM_D2_POS] = data_in[2];
    cw[HAM_D3_POS] = data_in[3];
  end

endmodule

// File: rtl/uart_hamming_transmitter.sv
// UART transmitter for Hamming(7,4) codewords: start bit, 7 codeword bits
// LSB first, stop bit; each bit lasts CLKS_PER_BIT enabled clocks.
module uart_hamming_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [3:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx,
  output logic       busy,
  output logic [1:0] state_out,
  output logic       done_out
);

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [2:0]      BIT_LAST = 3'd6;

  uart_state_e         state_r, state_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [2:0]          bit_r, bit_s;
  logic [HAM_CW_W-1:0] shift_r, shift_s;
  logic [HAM_CW_W-1:0] cw_s;
  logic                tx_r, tx_s;
  logic                done_s;
  logic                bit_end_s;

  hamming74_encoder u_enc (
    .data_in (data_in),
    .cw      (cw_s)
  );

  // Next-state, counter, shift-register and next-tx logic.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    bit_s     = bit_r;
    shift_s   = shift_r;
    done_s    = 1'b0;
    bit_end_s = (cnt_r == CNT_LAST);
    case (state_r)
      IDLE: begin
        if (valid_in) begin
          state_s = START;
          shift_s = cw_s;
          cnt_s   = '0;
          bit_s   = 3'd0;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          cnt_s   = '0;
          state_s = DATA;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          cnt_s   = '0;
          shift_s = {1'b0, shift_r[HAM_CW_W-1:1]};
          if (bit_r == BIT_LAST) begin
            state_s = STOP;
          end else begin
            bit_s = bit_r + 3'd1;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      STOP: begin
        if (bit_end_s) begin
          cnt_s   = '0;
          done_s  = 1'b1;
          state_s = IDLE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
        bit_s   = 3'd0;
        shift_s = '0;
      end
    endcase

    // tx is registered, so derive it from the state being entered.
    case (state_s)
      START:   tx_s = 1'b0;
      DATA:    tx_s = shift_s[0];
      default: tx_s = 1'b1;
    endcase
  end

  // State and datapath registers; everything holds while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      bit_r   <= 3'd0;
      shift_r <= '0;
      tx_r    <= 1'b1;
    end else if (ena) begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      tx_r    <= tx_s;
    end
  end

  assign tx        = tx_r;
  assign ready_out = (state_r == IDLE);
  assign busy      = (state_r != IDLE);
  assign state_out = state_r;
  // The stop bit only ends on an enabled edge, so the pulse is gated by ena.
  assign done_out  = done_s & ena;

endmodule

// File: tb/tb_uart_hamming_transmitter.sv
// Self-checking bench: a frame-position reference model checks every output
// on every falling edge; directed frames pin literal codewords and timing.
module tb_uart_hamming_transmitter;

  localparam int CPB   = 8;
  localparam int FRAME = 9 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [3:0] data_in = 4'h0;
  logic       valid_in = 1'b0;
  logic       ready_out, tx, busy, done_out;
  logic [1:0] state_out;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  uart_hamming_transmitter #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .tx        (tx),
    .busy      (busy),
    .state_out (state_out),
    .done_out  (done_out)
  );

  always #5 clk = ~clk;

  // Hamming(7,4) codeword straight from the parity equations.
  function automatic logic [6:0] hcw(input logic [3:0] d);
    logic p1, p2, p4;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: idle, or a position within a 9-bit frame.
  bit         m_active = 1'b0;
  int         m_pos = 0;
  logic [8:0] m_frame = 9'h1FF;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_pos    <= 0;
    end else if (ena) begin
      if (!m_active) begin
        if (valid_in) begin
          m_active <= 1'b1;
          m_pos    <= 0;
          m_frame  <= {1'b1, hcw(data_in), 1'b0};
        end
      end else if (m_pos == FRAME - 1) begin
        m_active <= 1'b0;
      end else begin
        m_pos <= m_pos + 1;
      end
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic       e_tx, e_done;
      logic [1:0] e_st;
      if (!m_active) begin
        e_tx = 1'b1; e_st = 2'b00; e_done = 1'b0;
      end else begin
        e_tx   = m_frame[m_pos / CPB];
        e_st   = (m_pos < CPB) ? 2'b01 : (m_pos < 8 * CPB) ? 2'b10 : 2'b11;
        e_done = (m_pos == FRAME - 1) && ena;
      end
      chk("tx", tx, e_tx);
      chk("state_out", state_out, e_st);
      chk("ready_out", ready_out, !m_active);
      chk("busy", busy, m_active);
      chk("done_out", done_out, e_done);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Follow one frame already started; sample mid-bit, optionally stall ena.
  task automatic capture(input int gap_at, input int gap_len,
                         output logic [8:0] cap, output int n, output int done_n,
                         output int total);
    int guard;
    cap = 9'h000; n = 0; done_n = -1; total = 0; guard = 0;
    while (!ready_out && guard < 400) begin
      if (n % CPB == CPB / 2) cap[n / CPB] = tx;
      if (done_out) done_n = n;
      if (n == gap_at) begin
        ena = 1'b0;
        repeat (gap_len) begin
          data_in = 4'($urandom); valid_in = 1'($urandom);
          step(); total++; guard++;
        end
        ena = 1'b1;
      end
      data_in  = 4'($urandom);
      valid_in = (n < FRAME - 8) ? 1'($urandom) : 1'b0;
      step(); n++; total++; guard++;
    end
    valid_in = 1'b0;
    if (guard >= 400) chk("frame_timeout", guard, 0);
  endtask

  task automatic run_frame(input string nm, input logic [3:0] d, input logic [6:0] exp_cw,
                           input int gap_at, input int gap_len);
    logic [8:0] cap;
    int n, done_n, total;
    data_in = d; valid_in = 1'b1;
    step();
    capture(gap_at, gap_len, cap, n, done_n, total);
    chk({nm, "_bits"}, cap, {1'b1, exp_cw, 1'b0});
    chk({nm, "_len"}, total, FRAME + gap_len);
    chk({nm, "_done_at"}, done_n, FRAME - 1);
  endtask

  initial begin
    logic [8:0] cap;
    int n, done_n, total, guard;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    chk("reset_tx", tx, 1'b1);
    chk("reset_state", state_out, 2'b00);
    chk("reset_ready", ready_out, 1'b1);
    chk("reset_done", done_out, 1'b0);
    repeat (100) step();
    chk("idle_tx", tx, 1'b1);

    run_frame("f_B", 4'hB, 7'h55, -1, 0);
    step();
    run_frame("f_0", 4'h0, 7'h00, -1, 0);
    step();
    run_frame("f_F", 4'hF, 7'h7F, -1, 0);
    step();
    run_frame("f_ena", 4'hB, 7'h55, 4 * CPB + 2, 20);
    step();

    // Back-to-back with valid held: exactly one idle cycle between frames.
    data_in = 4'h3; valid_in = 1'b1;
    step();
    data_in = 4'hC;
    n = 0;
    while (!ready_out && n < 400) begin step(); n++; end
    chk("b2b_len1", n, FRAME);
    step();
    chk("b2b_gap", ready_out, 1'b0);
    valid_in = 1'b0;
    capture(-1, 0, cap, n, done_n, total);
    chk("b2b_bits2", cap, {1'b1, 7'h61, 1'b0});
    chk("b2b_len2", total, FRAME);
    step();

    // Mid-frame reset during DATA, then a clean frame.
    data_in = 4'hB; valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    repeat (30) step();
    chk("pre_rst_state", state_out, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_state", state_out, 2'b00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_frame("f_after_rst", 4'h6, 7'h33, -1, 0);

    // Randomized traffic with ena gating; the model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      ena      = ($urandom_range(0, 3) != 0);
      valid_in = ($urandom_range(0, 9) < 3);
      data_in  = 4'($urandom);
      step();
    end
    ena = 1'b1; valid_in = 1'b0;
    guard = 0;
    while (!ready_out && guard < 200) begin step(); guard++; end
    chk("final_idle", ready_out, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
